// File: rtl/chip_driver_pkg.sv
// Shared definitions for the speckle sensor chip driver: state encoding,
// default serializer geometry and small elaboration helpers.
package chip_driver_pkg;

    localparam logic [1:0] ST_ENC_IDLE     = 2'd0;
    localparam logic [1:0] ST_ENC_SHIFT_LO = 2'd1;
    localparam logic [1:0] ST_ENC_SHIFT_HI = 2'd2;
    localparam logic [1:0] ST_ENC_LOAD     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_ENC_IDLE,
        ST_SHIFT_LO = ST_ENC_SHIFT_LO,
        ST_SHIFT_HI = ST_ENC_SHIFT_HI,
        ST_LOAD     = ST_ENC_LOAD
    } state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_LOAD_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chip_serializer_sclk_divider.sv
// Phase timer for the serializer: counts cycles within the current phase and
// flags the last one; the FSM clears it on every phase change.
module sclk_divider #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [PW-1:0] limit,
    output logic          phase_end
);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign phase_end = (cnt == (limit - PW'(1)));

endmodule

// File: rtl/chip_serializer.sv
// Serial configuration driver: shifts a captured word MSB-first on a divided
// serial clock, then strobes sload so the sensor latches it.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start, all pins low
// SHIFT_LO | sclk low, current bit presented on sdata
// SHIFT_HI | sclk high, sdata held for the chip to sample
// LOAD     | sload high for LOAD_CYCLES, then done pulse
module chip_serializer
    import chip_driver_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sdata,
    output logic             sload
);

    localparam int PW = $clog2(max_int(CLK_DIV, LOAD_CYCLES)) + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] DIV_LIM  = PW'(CLK_DIV);
    localparam logic [PW-1:0] LOAD_LIM = PW'(LOAD_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("chip_serializer: WIDTH must be >= 2");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("chip_serializer: CLK_DIV must be >= 1");
        end
        if (LOAD_CYCLES < 1) begin : g_bad_load
            $error("chip_serializer: LOAD_CYCLES must be >= 1");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bitcnt, bitcnt_nxt;
    logic [PW-1:0]    ph_limit;
    logic             ph_clear;
    logic             ph_end;

    sclk_divider #(
        .PW(PW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (ph_clear),
        .limit    (ph_limit),
        .phase_end(ph_end)
    );

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        ph_limit   = DIV_LIM;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    shreg_nxt  = data_in;
                    bitcnt_nxt = LAST_BIT;
                    state_nxt  = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (ph_end) begin
                    state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (ph_end) begin
                    if (bitcnt == '0) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
                        bitcnt_nxt = bitcnt - BW'(1);
                        state_nxt  = ST_SHIFT_LO;
                    end
                end
            end
            ST_LOAD: begin
                ph_limit = LOAD_LIM;
                if (ph_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // The timer restarts on every phase boundary and is parked while idle.
        ph_clear = (state == ST_IDLE) || (state_nxt != state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
        end
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sclk  <= 1'b0;
            sdata <= 1'b0;
            sload <= 1'b0;
        end else begin
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state == ST_LOAD) && (state_nxt == ST_IDLE);
            sclk  <= (state_nxt == ST_SHIFT_HI);
            sload <= (state_nxt == ST_LOAD);
            sdata <= ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI))
                     ? shreg_nxt[WIDTH-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_chip_serializer.sv
// Directed bench for chip_serializer: default geometry instance plus a small
// WIDTH=4 / CLK_DIV=1 / LOAD_CYCLES=1 instance.
module tb_chip_serializer;

    localparam int NREC = 300;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        busy, done, sclk, sdata, sload;

    logic        s_rst;
    logic        s_start;
    logic [3:0]  s_data;
    logic        s_busy, s_done, s_sclk, s_sdata, s_sload;

    int vec_cnt = 0;
    int err_cnt = 0;
    int stab_viol = 0;

    logic        sched_start [0:NREC-1];
    logic [15:0] sched_data  [0:NREC-1];
    logic        sched_rst   [0:NREC-1];
    logic        r_sclk  [0:NREC-1];
    logic        r_sdata [0:NREC-1];
    logic        r_sload [0:NREC-1];
    logic        r_busy  [0:NREC-1];
    logic        r_done  [0:NREC-1];

    chip_serializer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data_in(data_in),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .sdata  (sdata),
        .sload  (sload)
    );

    chip_serializer #(
        .WIDTH      (4),
        .CLK_DIV    (1),
        .LOAD_CYCLES(1)
    ) dut_small (
        .clk    (clk),
        .rst    (s_rst),
        .start  (s_start),
        .data_in(s_data),
        .busy   (s_busy),
        .done   (s_done),
        .sclk   (s_sclk),
        .sdata  (s_sdata),
        .sload  (s_sload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sdata must hold whenever sclk stays high across consecutive samples.
    logic p_sclk = 1'b0, p_sdata = 1'b0, ps_sclk = 1'b0, ps_sdata = 1'b0;
    always @(negedge clk) begin
        if (!rst && p_sclk && sclk && (sdata !== p_sdata)) stab_viol++;
        if (!s_rst && ps_sclk && s_sclk && (s_sdata !== ps_sdata)) stab_viol++;
        p_sclk   = sclk;
        p_sdata  = sdata;
        ps_sclk  = s_sclk;
        ps_sdata = s_sdata;
    end

    task automatic clear_sched();
        for (int i = 0; i < NREC; i++) begin
            sched_start[i] = 1'b0;
            sched_data[i]  = 16'h0000;
            sched_rst[i]   = 1'b0;
        end
    endtask

    // Entered just after a rising edge; cycle c spans edge c .. edge c+1.
    task automatic observe(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rst     = sched_rst[c];
            start   = sched_start[c];
            data_in = sched_data[c];
            @(negedge clk);
            r_sclk[c]  = sclk;
            r_sdata[c] = sdata;
            r_sload[c] = sload;
            r_busy[c]  = busy;
            r_done[c]  = done;
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        clear_sched();
    endtask

    task automatic analyze(input int lo, input int hi,
                           output int nrise, output int first_rise, output int bad_gap,
                           output logic [15:0] word,
                           output int nload, output int first_load,
                           output int ndone, output int first_done);
        int last;
        nrise = 0; first_rise = -1; bad_gap = 0; word = 16'h0000;
        nload = 0; first_load = -1; ndone = 0; first_done = -1; last = -1;
        for (int c = lo; c <= hi; c++) begin
            if (r_sclk[c] && !r_sclk[c-1]) begin
                if (nrise == 0) first_rise = c;
                else if (c - last != 8) bad_gap++;
                last = c;
                nrise++;
                word = {word[14:0], r_sdata[c]};
            end
            if (r_sload[c]) begin
                if (nload == 0) first_load = c;
                nload++;
            end
            if (r_done[c]) begin
                if (ndone == 0) first_done = c;
                ndone++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        start = 1'b0; data_in = 16'h0000; s_start = 1'b0; s_data = 4'h0;
        clear_sched();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({sclk, sdata, sload, busy, done} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_default: outputs=%b required=00000", {sclk, sdata, sload, busy, done});
        end
        vec_cnt++;
        if ({s_sclk, s_sdata, s_sload, s_busy, s_done} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_small: outputs=%b required=00000", {s_sclk, s_sdata, s_sload, s_busy, s_done});
        end
        rst = 1'b0; s_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int nr, fr, bg, nl, fl, nd, fd;
        logic [15:0] w;
        sched_start[0] = 1'b1;
        sched_data[0]  = 16'hA5C3;
        observe(140);
        analyze(1, 139, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (r_busy[1] !== 1'b1 || r_sclk[1] !== 1'b0 || r_sdata[1] !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_cycle1: busy/sclk/sdata=%b%b%b required=101", r_busy[1], r_sclk[1], r_sdata[1]);
        end
        vec_cnt++;
        if (nr !== 16 || fr !== 5 || bg !== 0) begin
            err_cnt++;
            $display("FAIL basic_edges: count=%0d first=%0d badgaps=%0d required 16/5/0", nr, fr, bg);
        end
        vec_cnt++;
        if (w !== 16'hA5C3) begin
            err_cnt++;
            $display("FAIL basic_word: got=%h required=a5c3", w);
        end
        vec_cnt++;
        if (nl !== 2 || fl !== 129) begin
            err_cnt++;
            $display("FAIL basic_sload: count=%0d first=%0d required 2/129", nl, fl);
        end
        vec_cnt++;
        if (nd !== 1 || fd !== 131) begin
            err_cnt++;
            $display("FAIL basic_done: count=%0d first=%0d required 1/131", nd, fd);
        end
        vec_cnt++;
        if (r_busy[130] !== 1'b1 || r_busy[131] !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_busy_end: busy130=%b busy131=%b required 1/0", r_busy[130], r_busy[131]);
        end
    endtask

    task automatic test_ignore_busy();
        int nr, fr, bg, nl, fl, nd, fd;
        logic [15:0] w;
        for (int i = 1; i < NREC; i++) sched_data[i] = 16'hFFFF;
        sched_start[0]   = 1'b1;
        sched_data[0]    = 16'hA5C3;
        sched_start[10]  = 1'b1;
        sched_start[100] = 1'b1;
        observe(140);
        analyze(1, 139, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (w !== 16'hA5C3 || nr !== 16) begin
            err_cnt++;
            $display("FAIL ignore_word: got=%h edges=%0d required=a5c3/16", w, nr);
        end
        vec_cnt++;
        if (nd !== 1 || fd !== 131) begin
            err_cnt++;
            $display("FAIL ignore_done: count=%0d first=%0d required 1/131", nd, fd);
        end
    endtask

    task automatic test_reset_midway();
        int nr, fr, bg, nl, fl, nd, fd;
        logic [15:0] w;
        sched_start[0]  = 1'b1;
        sched_data[0]   = 16'hA5C3;
        sched_rst[60]   = 1'b1;
        sched_start[65] = 1'b1;
        sched_data[65]  = 16'h0001;
        observe(200);
        vec_cnt++;
        if ({r_sclk[60], r_sdata[60], r_sload[60], r_busy[60], r_done[60]} !== 5'b0) begin
            err_cnt++;
            $display("FAIL midrst_outputs: got=%b required=00000",
                     {r_sclk[60], r_sdata[60], r_sload[60], r_busy[60], r_done[60]});
        end
        analyze(1, 64, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (nd !== 0 || nl !== 0 || r_busy[61] !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_abort: done=%0d sload=%0d busy61=%b required 0/0/0", nd, nl, r_busy[61]);
        end
        analyze(66, 199, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (w !== 16'h0001 || nr !== 16 || fr !== 70) begin
            err_cnt++;
            $display("FAIL midrst_restart_word: got=%h edges=%0d first=%0d required 0001/16/70", w, nr, fr);
        end
        vec_cnt++;
        if (nd !== 1 || fd !== 196) begin
            err_cnt++;
            $display("FAIL midrst_restart_done: count=%0d first=%0d required 1/196", nd, fd);
        end
    endtask

    task automatic test_back_to_back();
        int nr, fr, bg, nl, fl, nd, fd;
        logic [15:0] w;
        sched_start[0]   = 1'b1;
        sched_data[0]    = 16'h00FF;
        sched_start[131] = 1'b1;
        sched_data[131]  = 16'h1234;
        observe(270);
        analyze(1, 131, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (w !== 16'h00FF || nd !== 1 || fd !== 131) begin
            err_cnt++;
            $display("FAIL b2b_first: word=%h done=%0d@%0d required 00ff 1@131", w, nd, fd);
        end
        vec_cnt++;
        if (r_busy[131] !== 1'b0 || r_busy[132] !== 1'b1 || r_sdata[132] !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_restart: busy131=%b busy132=%b sdata132=%b required 0/1/0",
                     r_busy[131], r_busy[132], r_sdata[132]);
        end
        analyze(132, 269, nr, fr, bg, w, nl, fl, nd, fd);
        vec_cnt++;
        if (w !== 16'h1234 || nr !== 16 || fr !== 136 || bg !== 0) begin
            err_cnt++;
            $display("FAIL b2b_second_word: got=%h edges=%0d first=%0d gaps=%0d required 1234/16/136/0", w, nr, fr, bg);
        end
        vec_cnt++;
        if (nd !== 1 || fd !== 262 || fl !== 260) begin
            err_cnt++;
            $display("FAIL b2b_second_done: count=%0d done=%0d sload=%0d required 1/262/260", nd, fd, fl);
        end
    endtask

    task automatic test_small_config();
        logic [4:0] exp;
        logic e_sclk, e_sdata;
        @(posedge clk);
        #1;
        s_start = 1'b1;
        s_data  = 4'b1010;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_data  = 4'b0101;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e_sclk  = (c <= 8) && (c % 2 == 0);
            e_sdata = (c <= 8) && (((c - 1) / 2) % 2 == 0);
            exp = {e_sclk, e_sdata, (c == 9), (c <= 9), (c == 10)};
            vec_cnt++;
            if ({s_sclk, s_sdata, s_sload, s_busy, s_done} !== exp) begin
                err_cnt++;
                $display("FAIL small_cycle%0d: sclk/sdata/sload/busy/done=%b required=%b",
                         c, {s_sclk, s_sdata, s_sload, s_busy, s_done}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sdata_stability();
        vec_cnt++;
        if (stab_viol !== 0) begin
            err_cnt++;
            $display("FAIL sdata_stability: violations=%0d required=0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_busy();
        test_reset_midway();
        test_back_to_back();
        test_small_config();
        test_sdata_stability();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
